// File: rtl/iiitb_bcd_pkg.sv
// Shared definitions for the serial BCD subtractor.
//   state_e   : controller states (IDLE, RUN, DONE)
//   BCD_RADIX : decimal radix used for the borrow correction
//   BCD_MAX   : largest legal BCD digit value
//   DIG_W     : bits per packed BCD digit
package iiitb_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BCD_RADIX = 10;
  localparam int BCD_MAX   = 9;
  localparam int DIG_W     = 4;

endpackage

// File: rtl/iiitb_bcd_sub_digit.sv
// Combinational single-digit BCD subtractor.
//   a_d     : minuend digit
//   b_d     : subtrahend digit
//   bin     : borrow in
//   d       : difference digit (t, or t + radix when t is negative)
//   bout    : borrow out (t was negative)
//   invalid : either operand digit exceeds the largest BCD value
module iiitb_bcd_sub_digit
  import iiitb_bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       invalid
);

  // Six signed bits cover every 4-bit operand pair (-16..15), so the
  // radix correction is applied to the untruncated difference.
  logic signed [5:0] t;

  always_comb begin
    t       = $signed({2'b00, a_d}) - $signed({2'b00, b_d}) - $signed({5'b0_0000, bin});
    bout    = t[5];
    d       = bout ? 4'(t + $signed(6'(BCD_RADIX))) : t[3:0];
    invalid = (a_d > 4'(BCD_MAX)) || (b_d > 4'(BCD_MAX));
  end

endmodule

// File: rtl/iiitb_bcd_sub.sv
// Digit-serial packed-BCD subtractor: diff = a - b - borrow_in, one digit
// per clock, least significant digit first, ten's-complement on underflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (accepted only when idle)
//   a, b       : packed BCD operands, digit 0 in [3:0]
//   borrow_in  : borrow into digit 0
//   diff       : packed BCD result, held until the next accepted start
//   borrow_out : borrow out of the top digit (result is negative)
//   busy       : operation in progress (RUN or DONE)
//   done       : one-cycle completion pulse
//   err        : non-BCD operand digit seen; exists only when the macro
//                IIITB_BCD_SUB_CHK_EN is defined
module iiitb_bcd_sub
  import iiitb_bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              borrow_in,
  output logic [4*NDIG-1:0] diff,
  output logic              borrow_out,
  output logic              busy,
  output logic              done
`ifdef IIITB_BCD_SUB_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int W  = DIG_W * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            brw_q, brw_d;     // running borrow between digits
  logic            bout_q, bout_d;

  logic [3:0]      cur_a, cur_b;
  logic [3:0]      dig_d;
  logic            dig_bout;

`ifdef IIITB_BCD_SUB_CHK_EN
  logic            err_q, err_d;
  logic            dig_inv;
`else
  logic            dig_inv_unused;
`endif

  // Select the digit pair addressed by the current index.
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_a = opa_q[i*DIG_W +: DIG_W];
        cur_b = opb_q[i*DIG_W +: DIG_W];
      end
    end
  end

  iiitb_bcd_sub_digit u_digit (
    .a_d     (cur_a),
    .b_d     (cur_b),
    .bin     (brw_q),
    .d       (dig_d),
    .bout    (dig_bout),
`ifdef IIITB_BCD_SUB_CHK_EN
    .invalid (dig_inv)
`else
    .invalid (dig_inv_unused)
`endif
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef IIITB_BCD_SUB_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          brw_d   = borrow_in;
          idx_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
`ifdef IIITB_BCD_SUB_CHK_EN
          err_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NDIG; i++) begin
          if (idx_q == IW'(i)) diff_d[i*DIG_W +: DIG_W] = dig_d;
        end
        brw_d = dig_bout;
`ifdef IIITB_BCD_SUB_CHK_EN
        if (dig_inv) err_d = 1'b1;
`endif
        if (idx_q == IW'(NDIG-1)) begin
          bout_d  = dig_bout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef IIITB_BCD_SUB_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef IIITB_BCD_SUB_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
`ifdef IIITB_BCD_SUB_CHK_EN
  assign err        = err_q;
`endif

endmodule
